// File: rtl/pipe_pkg.sv
// Shared width helper for the pipe_reg_chain slice.
package pipe_pkg;

  function automatic int OCC_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: data register plus valid bit.
// Flush clears only the valid bit, and an invalid source never overwrites the held data.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             adv,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_vld <= 1'b0;
      r_dat <= RESET_VAL;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (adv) begin
      r_vld <= src_valid;
      if (src_valid) begin
        r_dat <= src_data;
      end
    end
  end

  assign o_valid = r_vld;
  assign o_data  = r_dat;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready pipeline register with bubble collapsing and flush; DEPTH cycles in to out.
// Define PIPE_OCC_EN to add the occupancy output and its up/down counter.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
  ,
  output logic [OCC_W(DEPTH)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] w_vld;
  logic [WIDTH-1:0] w_dat [DEPTH];
  logic [DEPTH:0]   w_adv;

  // Empty stages always advance, so items pack toward the output even when stalled.
  always_comb begin
    w_adv        = '0;
    w_adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i] = !w_vld[i] || w_adv[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             w_src_vld;
    logic [WIDTH-1:0] w_src_dat;

    if (g == 0) begin : g_head
      assign w_src_vld = in_valid;
      assign w_src_dat = in_data;
    end else begin : g_body
      assign w_src_vld = w_vld[g-1];
      assign w_src_dat = w_dat[g-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .adv       (w_adv[g]),
      .flush     (flush),
      .src_valid (w_src_vld),
      .src_data  (w_src_dat),
      .o_valid   (w_vld[g]),
      .o_data    (w_dat[g])
    );
  end

  assign in_ready  = w_adv[0] && !flush;
  assign out_valid = w_vld[DEPTH-1] && !flush;
  assign out_data  = w_dat[DEPTH-1];

`ifdef PIPE_OCC_EN
  localparam int unsigned OW = OCC_W(DEPTH);

  logic [OW-1:0] r_occ;
  logic          w_push;
  logic          w_pop;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_push && !w_pop) begin
      r_occ <= r_occ + OW'(1);
    end else if (w_pop && !w_push) begin
      r_occ <= r_occ - OW'(1);
    end
  end

  assign occupancy = r_occ;
`endif

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised multi-stage pipeline register with per-stage valid bits, valid/ready handshake, bubble collapsing and synchronous flush. It generalises the team's single-bit D flip-flops to a WIDTH-bit, DEPTH-stage datapath register. It is used wherever timing paths need retiming without losing backpressure, for example between bus interfaces and datapath blocks.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
RESET_VAL, 0, value loaded into every stage data register on reset (WIDTH bits)

Ports:
clk  in  1  clock; all state updates on posedge
rstn  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of all stage valid bits
in_valid  in  1  upstream data valid
in_ready  out  1  block can accept in_data this cycle
in_data  in  WIDTH  upstream data
out_valid  out  1  last stage holds valid data
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  WIDTH  last stage data register
occupancy  out  $clog2(DEPTH+1)  number of valid stages (only present with PIPE_OCC_EN)

Behaviour:
- Stages are numbered 0 (input) to DEPTH-1 (output). Each stage holds a data register and a valid bit.
- Reset (rstn=1) takes effect immediately, without waiting for a clock edge:
  - all valid bits are cleared to 0, so out_valid=0;
  - all data registers load RESET_VAL, so out_data=RESET_VAL;
  - occupancy=0.
- Reset may be asserted mid-operation; any in-flight data is discarded.
- Handshake rule: a transfer occurs on any edge where valid=1 and ready=1. Data must not change while valid=1 and ready=0.
- Advance rule, with stage DEPTH acting as the downstream (ready = out_ready):
  - adv[i] = !valid[i] || adv[i+1]
  - adv[DEPTH] = out_ready
  - in_ready = adv[0] && !flush
  - The ready path is combinational through all stages; this is an accepted timing cost.
- Per edge, for each stage i with adv[i]=1:
  - valid[i] <= valid[i-1], and data[i] <= data[i-1] when valid[i-1]=1;
  - stage 0 takes in_valid and in_data instead.
  - A stage with adv[i]=0 holds both valid and data.
  - A data register is never written by an invalid source; it keeps its old value.
- Bubble collapsing: an empty stage always accepts from upstream, even when out_ready=0. The chain therefore packs toward the output and can hold DEPTH items.
- Latency: an item accepted at edge n with no stalls appears with out_valid=1 after edge n+DEPTH-1. That is DEPTH cycles from in_valid to out_valid.
- Throughput: one item per cycle when out_ready=1 continuously.
- Full: all DEPTH valid bits set and out_ready=0 gives in_ready=0.
- Full with out_ready=1: an output pop and an input push occur on the same edge. Occupancy is unchanged.
- Empty: out_valid=0, and out_data holds its last value (RESET_VAL after reset).
- flush=1:
  - in_ready=0 and out_valid=0 combinationally, so no handshake completes in that cycle;
  - at the edge, all valid bits clear; data registers hold;
  - flush has priority over in_valid and out_ready.
- With DEPTH=1 the block is a single registered stage with a valid bit and full throughput (adv[0] = !valid[0] || out_ready).

Optional Feature:
- Macro: PIPE_OCC_EN.
- Defined: the occupancy output and a registered up/down counter are present.
  - Counter update: +1 on input handshake, -1 on output handshake, no change when both occur on the same edge.
  - Cleared to 0 by reset and by flush.
  - Never exceeds DEPTH.
- Undefined: the occupancy port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Package pipe_pkg holds the OCC_W width function, clog2(DEPTH+1).
- Sub-module pipe_stage contains one data register plus valid bit, with inputs adv, flush, src_valid, src_data.
- pipe_reg_chain instantiates DEPTH pipe_stage instances via generate and holds the ready chain and the optional counter.

Test Plan:
- WIDTH=8, DEPTH=3, out_ready=1. Push 0x11, 0x22, 0x33 on consecutive edges.
  - Expected: out_valid=1 with out_data 0x11, 0x22, 0x33 on three consecutive cycles, beginning 3 cycles after the first push.
  - in_ready stays 1 throughout.
- out_ready=0. Push 0x11, 0x22, 0x33, 0x44.
  - Expected: first three accepted, in_ready=0 while 0x44 is offered, occupancy=3.
  - Then raise out_ready: outputs 0x11, 0x22, 0x33, 0x44 in order, with 0x44 accepted on the first pop edge.
- Bubble collapse: push 0xA5, hold out_ready=0, wait 5 cycles, then push 0x5A.
  - Expected: 0xA5 is at the output after 3 cycles; 0x5A is accepted immediately; occupancy=2.
- Full, with out_ready=1 and in_valid=1 (0x77) on the same edge.
  - Expected: one pop and one push; occupancy stays 3; 0x77 emerges after the 2 older items.
- Full chain, flush=1 for 1 cycle with in_valid=1.
  - Expected: in_ready=0 and out_valid=0 during flush; next cycle out_valid=0, occupancy=0, 0x?? input not captured.
- Full chain mid-stream, raise rstn asynchronously between clock edges (RESET_VAL=0xC3).
  - Expected: out_valid=0 and out_data=0xC3 before the next edge, occupancy=0.
  - After rstn=0, the first push reappears after 3 cycles.
